mc_controller_hs: RTL and testbench

//  Next-generation multi-cycle RV32I control FSM for the processor top; drives the existing data_path control set.

---
 rtl/mc_controller_hs.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_mc_controller_hs.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller_hs.sv
// -----------------------------------------------------------------------------
// mc_controller_hs
// Multi-cycle RV32I control FSM that drives the data_path control set.
// Memory accesses in FETCH/MEMREAD/MEMWRITE wait for a ready handshake. A
// run of wait cycles that is too long sends the FSM to TRAP. An illegal opcode
// or an unsupported branch func3 also sends it to TRAP. Retired
// instructions are counted.
//
// Ports
//   clk, rst           clock (rising edge), synchronous active-high reset
//   op, func3, func7   instruction fields from IR (func7 currently unused)
//   zero, negetive     ALU flags used to resolve branches
//   mem_ready          memory completes the current access this cycle
//   pc_en .. imm_src   data_path control strobes and mux selects
//   mem_req            a memory access is in progress
//   trap               FSM is halted in TRAP (sticky until rst)
//   retire             one-cycle pulse when an instruction completes
//   instret            retired-instruction count, wraps to 0
// -----------------------------------------------------------------------------
module mc_controller_hs #(
    parameter bit MEM_HS  = 1'b1,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic             zero,
    input  logic             negetive,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             adr_src,
    output logic             mem_write,
    output logic             IR_write,
    output logic             reg_write,
    output logic [1:0]       alusrcA,
    output logic [1:0]       alusrcB,
    output logic [2:0]       aluop,
    output logic [1:0]       result_src,
    output logic [2:0]       imm_src,
    output logic             mem_req,
    output logic             trap,
    output logic             retire,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Wide enough to hold the value TIMEOUT itself.
    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LINK,
        S_LUI, S_TRAP
    } state_t;

    state_t            state_reg, state_next;
    logic [TW-1:0]     wait_cnt_reg, wait_cnt_next;
    logic [CNT_W-1:0]  instret_reg;

    logic mem_state;
    logic ready;
    logic timeout_hit;
    logic branch_valid;
    logic branch_taken;
    logic unused_func7;

    assign unused_func7 = ^func7;

    assign mem_state = (state_reg == S_FETCH) || (state_reg == S_MEMREAD) ||
                       (state_reg == S_MEMWRITE);

    // Without the handshake every access completes in its first cycle.
    assign ready = !MEM_HS || mem_ready;

    generate
        if (MEM_HS && (TIMEOUT != 0)) begin : g_timeout
            assign timeout_hit = mem_state && !mem_ready &&
                                 (wait_cnt_reg == TW'(TIMEOUT));
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    always_comb begin
        branch_valid = 1'b1;
        branch_taken = 1'b0;
        case (func3)
            3'b000:  branch_taken = zero;
            3'b001:  branch_taken = !zero;
            3'b100:  branch_taken = negetive;
            3'b101:  branch_taken = !negetive;
            default: branch_valid = 1'b0;
        endcase
    end

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_FETCH;
            wait_cnt_reg <= '0;
            instret_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (retire) begin
                instret_reg <= instret_reg + CNT_W'(1);
            end
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_next    = state_reg;
        // The wait counter runs only while an access is stalled. Any completed
        // access, or any non-memory state, clears it.
        wait_cnt_next = (mem_state && !ready && !timeout_hit) ?
                        wait_cnt_reg + TW'(1) : '0;
        case (state_reg)
            S_FETCH: begin
                if (timeout_hit)  state_next = S_TRAP;
                else if (ready)   state_next = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXEC_R;
                    OP_ITYPE:          state_next = S_EXEC_I;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_LUI:            state_next = S_LUI;
                    default:           state_next = S_TRAP;
                endcase
            end
            S_MEMADR:   state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: begin
                if (timeout_hit)  state_next = S_TRAP;
                else if (ready)   state_next = S_MEMWB;
            end
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: begin
                if (timeout_hit)  state_next = S_TRAP;
                else if (ready)   state_next = S_FETCH;
            end
            S_EXEC_R:   state_next = S_ALUWB;
            S_EXEC_I:   state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BRANCH:   state_next = branch_valid ? S_FETCH : S_TRAP;
            S_JAL:      state_next = S_LINK;
            S_JALR:     state_next = S_LINK;
            S_LINK:     state_next = S_FETCH;
            S_LUI:      state_next = S_FETCH;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_TRAP;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        pc_en      = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        IR_write   = 1'b0;
        reg_write  = 1'b0;
        alusrcA    = 2'b00;
        alusrcB    = 2'b00;
        aluop      = 3'b000;
        result_src = 2'b00;
        imm_src    = 3'b000;
        mem_req    = 1'b0;
        trap       = 1'b0;
        retire     = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_req    = 1'b1;
                alusrcB    = 2'b10;
                result_src = 2'b10;
                IR_write   = ready;
                pc_en      = ready;
            end
            S_DECODE: begin
                alusrcA = 2'b01;
                alusrcB = 2'b01;
                case (op)
                    OP_STORE:  imm_src = 3'b001;
                    OP_BRANCH: imm_src = 3'b010;
                    OP_JAL:    imm_src = 3'b011;
                    OP_LUI:    imm_src = 3'b100;
                    default:   imm_src = 3'b000;
                endcase
            end
            S_MEMADR: begin
                alusrcA = 2'b10;
                alusrcB = 2'b01;
                imm_src = (op == OP_STORE) ? 3'b001 : 3'b000;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                mem_req = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_req   = 1'b1;
                mem_write = ready;
                retire    = ready;
            end
            S_EXEC_R: begin
                alusrcA = 2'b10;
                aluop   = 3'b010;
            end
            S_EXEC_I: begin
                alusrcA = 2'b10;
                alusrcB = 2'b01;
                aluop   = 3'b011;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alusrcA = 2'b10;
                aluop   = 3'b001;
                pc_en   = branch_valid && branch_taken;
                retire  = branch_valid;
            end
            S_JAL: begin
                pc_en = 1'b1;
            end
            S_JALR: begin
                alusrcA    = 2'b10;
                alusrcB    = 2'b01;
                result_src = 2'b10;
                pc_en      = 1'b1;
            end
            S_LINK: begin
                alusrcA    = 2'b01;
                alusrcB    = 2'b10;
                result_src = 2'b10;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            S_LUI: begin
                imm_src    = 3'b100;
                result_src = 2'b11;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                trap = 1'b1;
            end
        endcase
        // Reset suppresses every output at once, so an aborted instruction
        // cannot write anything in the reset cycle.
        if (rst) begin
            pc_en      = 1'b0;
            adr_src    = 1'b0;
            mem_write  = 1'b0;
            IR_write   = 1'b0;
            reg_write  = 1'b0;
            alusrcA    = 2'b00;
            alusrcB    = 2'b00;
            aluop      = 3'b000;
            result_src = 2'b00;
            imm_src    = 3'b000;
            mem_req    = 1'b0;
            trap       = 1'b0;
            retire     = 1'b0;
        end
    end

    assign instret = rst ? '0 : instret_reg;

endmodule

// File: tb/tb_mc_controller_hs.sv
module tb_mc_controller_hs;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [6:0]       op;
    logic [2:0]       func3;
    logic [6:0]       func7;
    logic             zero, negetive, mem_ready;
    logic             pc_en, adr_src, mem_write, IR_write, reg_write;
    logic [1:0]       alusrcA, alusrcB, result_src;
    logic [2:0]       aluop, imm_src;
    logic             mem_req, trap, retire;
    logic [CNT_W-1:0] instret;

    mc_controller_hs #(.MEM_HS(1'b1), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
        .zero(zero), .negetive(negetive), .mem_ready(mem_ready),
        .pc_en(pc_en), .adr_src(adr_src), .mem_write(mem_write),
        .IR_write(IR_write), .reg_write(reg_write), .alusrcA(alusrcA),
        .alusrcB(alusrcB), .aluop(aluop), .result_src(result_src),
        .imm_src(imm_src), .mem_req(mem_req), .trap(trap), .retire(retire),
        .instret(instret)
    );

    typedef struct packed {
        logic       pc_en, adr_src, mem_write, ir_write, reg_write;
        logic [1:0] a, b;
        logic [2:0] alu;
        logic [1:0] rs;
        logic [2:0] imm;
        logic       mem_req, trap, retire;
    } ctl_t;

    localparam ctl_t NONE = '0;

    ctl_t act;
    assign act = {pc_en, adr_src, mem_write, IR_write, reg_write, alusrcA,
                  alusrcB, aluop, result_src, imm_src, mem_req, trap, retire};

    int vectors     = 0;
    int miscompares = 0;

    // ------------------------------------------------------------------
    // Instruction model: each instruction is a list of steps, each step is
    // the control word it must show. Memory steps hold until ready and add
    // their "on ready" strobes in the completing cycle.
    // ------------------------------------------------------------------
    ctl_t plan_base[8];
    ctl_t plan_rdy[8];
    logic plan_mem[8];
    int   plan_len;
    logic plan_traps;

    function automatic ctl_t mk(input logic pc, ad, mw, ir, rw,
                                input logic [1:0] a, b, input logic [2:0] alu,
                                input logic [1:0] rs, input logic [2:0] imm,
                                input logic mq, rt);
        ctl_t t;
        t.pc_en = pc; t.adr_src = ad; t.mem_write = mw; t.ir_write = ir;
        t.reg_write = rw; t.a = a; t.b = b; t.alu = alu; t.rs = rs;
        t.imm = imm; t.mem_req = mq; t.trap = 1'b0; t.retire = rt;
        return t;
    endfunction

    task automatic add_step(input ctl_t b, input ctl_t r, input logic m);
        plan_base[plan_len] = b;
        plan_rdy[plan_len]  = r;
        plan_mem[plan_len]  = m;
        plan_len++;
    endtask

    task automatic build_plan(input logic [6:0] o, input logic [2:0] f3,
                              input logic z, input logic n);
        logic [2:0] imm;
        logic       taken, valid;
        ctl_t       link;
        plan_len   = 0;
        plan_traps = 1'b0;
        case (o)
            7'b0100011: imm = 3'b001;
            7'b1100011: imm = 3'b010;
            7'b1101111: imm = 3'b011;
            7'b0110111: imm = 3'b100;
            default:    imm = 3'b000;
        endcase
        link = mk(0,0,0,0,1, 2'b01,2'b10,3'b000, 2'b10,3'b000, 0,1);
        add_step(mk(0,0,0,0,0, 2'b00,2'b10,3'b000, 2'b10,3'b000, 1,0),
                 mk(1,0,0,1,0, 2'b00,2'b00,3'b000, 2'b00,3'b000, 0,0), 1'b1);
        add_step(mk(0,0,0,0,0, 2'b01,2'b01,3'b000, 2'b00,imm, 0,0), NONE, 1'b0);
        case (o)
            7'b0000011: begin
                add_step(mk(0,0,0,0,0, 2'b10,2'b01,3'b000, 2'b00,3'b000, 0,0), NONE, 1'b0);
                add_step(mk(0,1,0,0,0, 2'b00,2'b00,3'b000, 2'b00,3'b000, 1,0), NONE, 1'b1);
                add_step(mk(0,0,0,0,1, 2'b00,2'b00,3'b000, 2'b01,3'b000, 0,1), NONE, 1'b0);
            end
            7'b0100011: begin
                add_step(mk(0,0,0,0,0, 2'b10,2'b01,3'b000, 2'b00,3'b001, 0,0), NONE, 1'b0);
                add_step(mk(0,1,0,0,0, 2'b00,2'b00,3'b000, 2'b00,3'b000, 1,0),
                         mk(0,0,1,0,0, 2'b00,2'b00,3'b000, 2'b00,3'b000, 0,1), 1'b1);
            end
            7'b0110011, 7'b0010011: begin
                if (o == 7'b0110011)
                    add_step(mk(0,0,0,0,0, 2'b10,2'b00,3'b010, 2'b00,3'b000, 0,0), NONE, 1'b0);
                else
                    add_step(mk(0,0,0,0,0, 2'b10,2'b01,3'b011, 2'b00,3'b000, 0,0), NONE, 1'b0);
                add_step(mk(0,0,0,0,1, 2'b00,2'b00,3'b000, 2'b00,3'b000, 0,1), NONE, 1'b0);
            end
            7'b1100011: begin
                valid = 1'b1;
                taken = 1'b0;
                case (f3)
                    3'b000:  taken = z;
                    3'b001:  taken = !z;
                    3'b100:  taken = n;
                    3'b101:  taken = !n;
                    default: valid = 1'b0;
                endcase
                add_step(mk(taken && valid,0,0,0,0, 2'b10,2'b00,3'b001, 2'b00,3'b000, 0,valid),
                         NONE, 1'b0);
                plan_traps = !valid;
            end
            7'b1101111: begin
                add_step(mk(1,0,0,0,0, 2'b00,2'b00,3'b000, 2'b00,3'b000, 0,0), NONE, 1'b0);
                add_step(link, NONE, 1'b0);
            end
            7'b1100111: begin
                add_step(mk(1,0,0,0,0, 2'b10,2'b01,3'b000, 2'b10,3'b000, 0,0), NONE, 1'b0);
                add_step(link, NONE, 1'b0);
            end
            7'b0110111: begin
                add_step(mk(0,0,0,0,1, 2'b00,2'b00,3'b000, 2'b11,3'b100, 0,1), NONE, 1'b0);
            end
            default: plan_traps = 1'b1;
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h", name, a, e);
        end
    endtask

    task automatic step_cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick_waits();
        int r;
        r = $urandom_range(0, 19);
        if (r < 10)      return 0;
        else if (r < 18) return $urandom_range(1, 4);
        else             return $urandom_range(12, 20);
    endfunction

    // Model state
    logic             trapped;
    int               idx, wcnt, trap_cycles, waits_left;
    logic             need_plan, step_entry;
    logic [CNT_W-1:0] instret_exp;
    ctl_t             exp_ctl;

    initial begin
        int   n;
        logic ir_seen;
        logic [6:0] ops [8];
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};

        rst = 1'b1; op = 7'b0110011; func3 = 3'b000; func7 = 7'b0;
        zero = 1'b0; negetive = 1'b0; mem_ready = 1'b1;

        // ---------------- directed: add x3,x1,x2 with ready tied high
        step_cyc();
        check("rst_ctl", 32'(act), 32'(NONE));
        check("rst_instret", instret, 32'd0);
        step_cyc();
        rst = 1'b0;
        #1;
        check("add_fetch_irw", 32'(IR_write), 32'd1);
        check("add_fetch_pcen", 32'(pc_en), 32'd1);
        step_cyc();                                   // DECODE
        step_cyc();                                   // EXEC_R
        check("add_exec_aluop", 32'(aluop), 32'd2);
        check("add_exec_rw", 32'(reg_write), 32'd0);
        step_cyc();                                   // ALUWB
        check("add_wb_rw", 32'(reg_write), 32'd1);
        check("add_wb_retire", 32'(retire), 32'd1);
        check("add_wb_instret", instret, 32'd0);
        step_cyc();                                   // FETCH again
        check("add_instret", instret, 32'd1);

        // ---------------- directed: illegal opcode traps after DECODE
        op = 7'b1111111;
        step_cyc();                                   // DECODE
        check("illop_decode_trap", 32'(trap), 32'd0);
        step_cyc();
        check("illop_trap", 32'(trap), 32'd1);

        // ---------------- directed: beq taken, bne not taken
        rst = 1'b1; step_cyc(); rst = 1'b0;
        op = 7'b1100011; func3 = 3'b000; zero = 1'b1;
        step_cyc(); step_cyc();                       // BRANCH
        check("beq_pcen", 32'(pc_en), 32'd1);
        func3 = 3'b001;
        #1;
        check("bne_pcen", 32'(pc_en), 32'd0);

        // ---------------- directed: fetch timeout
        rst = 1'b1; step_cyc(); rst = 1'b0; mem_ready = 1'b0;
        #1;
        n = 0; ir_seen = 1'b0;
        while (!trap && n < 40) begin
            if (IR_write) ir_seen = 1'b1;
            n++;
            step_cyc();
        end
        check("timeout_cycles", n, 32'd17);
        check("timeout_no_irw", 32'(ir_seen), 32'd0);
        rst = 1'b1; step_cyc(); rst = 1'b0; #1;
        check("timeout_rst_trap", 32'(trap), 32'd0);

        // ---------------- randomized run against the instruction model
        trapped = 1'b0; idx = 0; wcnt = 0; trap_cycles = 0; waits_left = 0;
        need_plan = 1'b1; step_entry = 1'b1; instret_exp = '0;
        for (int cyc = 0; cyc < 8000; cyc++) begin
            @(posedge clk);
            #1;
            rst = (cyc == 0) || (trapped && trap_cycles >= 3) ||
                  ($urandom_range(0, 299) == 0);
            func7 = 7'($urandom);
            if (need_plan) begin
                if ($urandom_range(0, 15) == 0) op = 7'($urandom);
                else                            op = ops[$urandom_range(0, 7)];
                if (op == 7'b1100011 && $urandom_range(0, 7) != 0)
                    func3 = {$urandom_range(0, 1) == 1, 1'b0, $urandom_range(0, 1) == 1};
                else
                    func3 = 3'($urandom);
                zero     = $urandom_range(0, 1) == 1;
                negetive = $urandom_range(0, 1) == 1;
                build_plan(op, func3, zero, negetive);
                need_plan = 1'b0;
            end
            if (!trapped && plan_mem[idx]) begin
                if (step_entry) waits_left = pick_waits();
                mem_ready = (waits_left == 0);
            end else begin
                mem_ready = $urandom_range(0, 1) == 1;
            end
            step_entry = 1'b0;
            #1;

            if (rst)          exp_ctl = NONE;
            else if (trapped) begin
                exp_ctl = NONE;
                exp_ctl.trap = 1'b1;
            end else
                exp_ctl = plan_base[idx] | (mem_ready ? plan_rdy[idx] : NONE);

            vectors++;
            if (act !== exp_ctl || instret !== (rst ? '0 : instret_exp)) begin
                miscompares++;
                $display("FAIL ctl cyc=%0d op=%b f3=%b rdy=%b actual=%h/%0d required=%h/%0d",
                         cyc, op, func3, mem_ready, act, instret, exp_ctl,
                         rst ? '0 : instret_exp);
            end

            if (rst) begin
                trapped = 1'b0; idx = 0; wcnt = 0; trap_cycles = 0;
                need_plan = 1'b1; step_entry = 1'b1; instret_exp = '0;
            end else if (trapped) begin
                trap_cycles++;
            end else if (plan_mem[idx] && !mem_ready) begin
                if (wcnt == TIMEOUT) begin
                    trapped = 1'b1;
                    trap_cycles = 0;
                end else begin
                    wcnt++;
                    waits_left--;
                end
            end else begin
                wcnt = 0;
                idx++;
                step_entry = 1'b1;
                if (idx == plan_len) begin
                    idx = 0;
                    if (plan_traps) begin
                        trapped = 1'b1;
                        trap_cycles = 0;
                    end else begin
                        instret_exp++;
                        need_plan = 1'b1;
                    end
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
